// File: rtl/pc_framer_pkg.sv
// Shared types and constants for the FPGA-to-PC upstream framer.
package pc_framer_pkg;

  localparam int unsigned NPC_CODE_DEF = 7;
  localparam int unsigned NPC_DATA_DEF = 20;

  // Default code assignments: spike-filter stream base and heartbeat base
  localparam int unsigned SF_CODE = 14;
  localparam int unsigned HB_CODE = 24;

  typedef struct packed {
    logic [NPC_CODE_DEF-1:0] code;
    logic [NPC_DATA_DEF-1:0] payload;
  } pc_word_t;

  typedef enum logic {
    IDLE,
    SEND
  } fsm_state_t;

  // Number of NPCdata-bit chunks needed to carry a field of the given width
  function automatic int unsigned nwords(input int unsigned width,
                                         input int unsigned npcdata = NPC_DATA_DEF);
    return (width + npcdata - 1) / npcdata;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
// The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic found;

  // Scan slots in rotated order starting at ptr; first requester wins
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i] && (i == (32'(ptr) + off) % N)) begin
          found   = 1'b1;
          gnt_idx = PW'(i);
        end
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      gnt[i] = en && found && (gnt_idx == PW'(i));
    end
  end

endmodule

// File: rtl/pc_upstream_framer.sv
// Upstream framer: merges N_STREAMS valid/ack message channels (plus an optional
// heartbeat slot) into one stream of (code, payload) PC words, round-robin per
// message. Define PC_UPSTREAM_FRAMER_HB_EN to enable the heartbeat source.
module pc_upstream_framer
  import pc_framer_pkg::*;
#(
  parameter int unsigned                  NPCcode      = NPC_CODE_DEF,
  parameter int unsigned                  NPCdata      = NPC_DATA_DEF,
  parameter int unsigned                  N_STREAMS    = 4,
  parameter int unsigned                  NIN          = 40,
  parameter logic [3*N_STREAMS-1:0]       WORDS        = {4{3'd2}},
  parameter logic [NPCcode*N_STREAMS-1:0] CODE_BASE    = {7'd20, 7'd18, 7'd16, 7'd14},
  parameter int unsigned                  Ntime_full   = 48,
  parameter int unsigned                  HB_CODE_BASE = HB_CODE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_STREAMS-1:0]     in_v,
  input  logic [N_STREAMS*NIN-1:0] in_d,
  output logic [N_STREAMS-1:0]     in_a,
  output logic                     out_v,
  output logic [NPCcode-1:0]       out_code,
  output logic [NPCdata-1:0]       out_payload,
  input  logic                     out_a,
  input  logic                     hb_pulse,
  input  logic [Ntime_full-1:0]    time_elapsed,
  output logic                     hb_overrun
);

`ifdef PC_UPSTREAM_FRAMER_HB_EN
  localparam int unsigned HB_SLOTS = 1;
`else
  localparam int unsigned HB_SLOTS = 0;
`endif
  localparam int unsigned SLOTS    = N_STREAMS + HB_SLOTS;
  localparam int unsigned IN_WORDS = nwords(NIN, NPCdata);
  localparam int unsigned HB_WORDS = nwords(Ntime_full, NPCdata);
  localparam int unsigned MAXW     = (HB_SLOTS != 0 && HB_WORDS > IN_WORDS) ? HB_WORDS : IN_WORDS;
  localparam int unsigned MSG_W    = MAXW * NPCdata;
  localparam int unsigned IW       = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int unsigned PW       = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [SLOTS-1:0]   req;
  logic [MSG_W-1:0]   slot_msg  [SLOTS];
  logic [IW-1:0]      slot_last [SLOTS];
  logic [NPCcode-1:0] slot_code [SLOTS];

  logic [SLOTS-1:0]   gnt;
  logic [PW-1:0]      gnt_idx;
  logic               granted;
  logic               grant_en;

  fsm_state_t         state;
  logic [MSG_W-1:0]   msg;
  logic [IW-1:0]      word_idx;
  logic [IW-1:0]      last_idx;
  logic [PW-1:0]      rr_ptr;

  for (genvar i = 0; i < N_STREAMS; i++) begin : g_stream
    if (WORDS[3*i +: 3] == 3'd0 || int'(WORDS[3*i +: 3]) > IN_WORDS) begin : g_bad_words
      $error("pc_upstream_framer: WORDS for stream %0d out of range 1..%0d", i, IN_WORDS);
    end
    assign req[i]       = in_v[i];
    assign slot_msg[i]  = MSG_W'(in_d[i*NIN +: NIN]);
    assign slot_last[i] = IW'(WORDS[3*i +: 3] - 3'd1);
    assign slot_code[i] = CODE_BASE[i*NPCcode +: NPCcode];
  end

`ifdef PC_UPSTREAM_FRAMER_HB_EN
  logic                  hb_pending;
  logic [Ntime_full-1:0] hb_time;
  logic                  hb_granted;

  assign req[N_STREAMS]       = hb_pending;
  assign slot_msg[N_STREAMS]  = MSG_W'(hb_time);
  assign slot_last[N_STREAMS] = IW'(HB_WORDS - 1);
  assign slot_code[N_STREAMS] = NPCcode'(HB_CODE_BASE);
  assign hb_granted           = granted && (gnt_idx == PW'(N_STREAMS));

  // Heartbeat capture; a pulse in the grant cycle queues a fresh heartbeat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hb_pending <= 1'b0;
      hb_time    <= '0;
      hb_overrun <= 1'b0;
    end else if (hb_pulse) begin
      hb_pending <= 1'b1;
      hb_time    <= time_elapsed;
      if (hb_pending && !hb_granted) hb_overrun <= 1'b1;
    end else if (hb_granted) begin
      hb_pending <= 1'b0;
    end
  end
`else
  logic unused_hb;
  assign unused_hb  = ^{hb_pulse, time_elapsed};
  assign hb_overrun = 1'b0;
`endif

  // A new message may be taken when idle or as the last word is accepted;
  // gating with reset keeps in_a low while reset is asserted.
  assign grant_en = reset && ((state == IDLE) || (out_v && out_a && word_idx == last_idx));
  assign granted  = |gnt;
  assign in_a     = gnt[N_STREAMS-1:0];

  rr_arbiter #(.N(SLOTS)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .en      (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Message FSM. The message register is shifted down one chunk per accepted
  // word and out_code is incremented, which is equivalent to indexing
  // msg[word_idx*NPCdata] and adding word_idx to the base code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      out_v       <= 1'b0;
      out_code    <= '0;
      out_payload <= '0;
      msg         <= '0;
      word_idx    <= '0;
      last_idx    <= '0;
      rr_ptr      <= '0;
    end else if (grant_en) begin
      if (granted) begin
        state       <= SEND;
        out_v       <= 1'b1;
        out_code    <= slot_code[gnt_idx];
        out_payload <= slot_msg[gnt_idx][NPCdata-1:0];
        msg         <= slot_msg[gnt_idx] >> NPCdata;
        word_idx    <= '0;
        last_idx    <= slot_last[gnt_idx];
        rr_ptr      <= (gnt_idx == PW'(SLOTS - 1)) ? '0 : gnt_idx + PW'(1);
      end else begin
        state <= IDLE;
        out_v <= 1'b0;
      end
    end else if (state == SEND && out_a) begin
      word_idx    <= word_idx + IW'(1);
      out_code    <= out_code + NPCcode'(1);
      out_payload <= msg[NPCdata-1:0];
      msg         <= msg >> NPCdata;
    end
  end

endmodule

// File: tb/tb_pc_upstream_framer.sv
// Directed self-checking bench for pc_upstream_framer (4 streams, stream 0 one
// word, streams 1..3 two words). Heartbeat checks follow PC_UPSTREAM_FRAMER_HB_EN.
module tb_pc_upstream_framer;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_v;
  logic [159:0] in_d;
  logic [3:0]   in_a;
  logic         out_v;
  logic [6:0]   out_code;
  logic [19:0]  out_payload;
  logic         out_a;
  logic         hb_pulse;
  logic [47:0]  time_elapsed;
  logic         hb_overrun;

  int errors = 0;
  int checks = 0;

  localparam logic [39:0] D0 = 40'h00000_ABCDE;
  localparam logic [39:0] D1 = 40'h12345_6789A;
  localparam logic [39:0] D2 = 40'hAAAAA_BBBBB;
  localparam logic [39:0] D3 = 40'hCCCCC_DDDDD;

  pc_upstream_framer #(
    .N_STREAMS (4),
    .NIN       (40),
    .WORDS     ({3'd2, 3'd2, 3'd2, 3'd1}),
    .CODE_BASE ({7'd20, 7'd18, 7'd16, 7'd14})
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_v         (in_v),
    .in_d         (in_d),
    .in_a         (in_a),
    .out_v        (out_v),
    .out_code     (out_code),
    .out_payload  (out_payload),
    .out_a        (out_a),
    .hb_pulse     (hb_pulse),
    .time_elapsed (time_elapsed),
    .hb_overrun   (hb_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string name, input logic [6:0] code, input logic [19:0] pay);
    chk({name, "_v"}, 64'(out_v), 64'd1);
    chk({name, "_code"}, 64'(out_code), 64'(code));
    chk({name, "_pay"}, 64'(out_payload), 64'(pay));
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_v     = '0;
    out_a    = 1'b1;
    hb_pulse = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic        oa;
    logic [3:0]  exp_a;
    logic        exp_v;
    logic [6:0]  exp_code;
    logic [19:0] exp_pay;
  } vec_t;

  vec_t vecs [9];

  logic [6:0]  ew_code [8];
  logic [19:0] ew_pay  [8];
  int          rr_order [8];
  int          gcnt, wcnt, wn;
  logic        started;
  logic [39:0] sdata [4];
  int          swords [4];
  int          sbase [4];

  initial begin
    // Reset-state check with every stream requesting
    in_d         = {D3, D2, D1, D0};
    time_elapsed = '0;
    hb_pulse     = 1'b0;
    out_a        = 1'b1;
    reset        = 1'b0;
    in_v         = 4'hF;
    tick();
    tick();
    chk("rst_in_a", 64'(in_a), 64'd0);
    chk("rst_out_v", 64'(out_v), 64'd0);
    chk("rst_code", 64'(out_code), 64'd0);
    chk("rst_pay", 64'(out_payload), 64'd0);
    chk("rst_overrun", 64'(hb_overrun), 64'd0);

    // Table: single word, then a stalled two-word message with a competing request
    vecs[0] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 7'd0,  20'h0};
    vecs[1] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 7'd14, 20'hABCDE};
    vecs[2] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 7'd0,  20'h0};
    vecs[3] = '{4'b0010, 1'b1, 4'b0010, 1'b0, 7'd0,  20'h0};
    vecs[4] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 7'd16, 20'h6789A};
    vecs[5] = '{4'b0011, 1'b1, 4'b0000, 1'b1, 7'd16, 20'h6789A};
    vecs[6] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 7'd17, 20'h12345};
    vecs[7] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 7'd14, 20'hABCDE};
    vecs[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 7'd0,  20'h0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_v  = vecs[i].v;
      out_a = vecs[i].oa;
      #1;
      chk($sformatf("vec%0d_in_a", i), 64'(in_a), 64'(vecs[i].exp_a));
      chk($sformatf("vec%0d_out_v", i), 64'(out_v), 64'(vecs[i].exp_v));
      if (vecs[i].exp_v) begin
        chk($sformatf("vec%0d_code", i), 64'(out_code), 64'(vecs[i].exp_code));
        chk($sformatf("vec%0d_pay", i), 64'(out_payload), 64'(vecs[i].exp_pay));
      end
      tick();
    end

    // Round robin with all streams valid and out_a toggling 1,0,1,0
    sdata  = '{D0, D1, D2, D3};
    swords = '{1, 2, 2, 2};
    sbase  = '{14, 16, 18, 20};
    rr_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    wn = 0;
    for (int g = 0; g < 8 && wn < 8; g++) begin
      for (int k = 0; k < swords[rr_order[g]] && wn < 8; k++) begin
        ew_code[wn] = 7'(sbase[rr_order[g]] + k);
        ew_pay[wn]  = 20'(sdata[rr_order[g]] >> (20 * k));
        wn++;
      end
    end
    do_reset();
    in_v    = 4'hF;
    gcnt    = 0;
    wcnt    = 0;
    started = 1'b0;
    for (int c = 0; c < 40 && wcnt < 8; c++) begin
      out_a = (c % 2 == 0);
      #1;
      if (in_a != 4'b0000) begin
        if (gcnt < 8) chk($sformatf("rr_grant%0d", gcnt), 64'(in_a), 64'(4'b0001 << rr_order[gcnt]));
        else chk("rr_extra_grant", 64'(in_a), 64'd0);
        gcnt++;
      end
      if (out_v) begin
        started = 1'b1;
        chk($sformatf("rr_w%0d_code", wcnt), 64'(out_code), 64'(ew_code[wcnt]));
        chk($sformatf("rr_w%0d_pay", wcnt), 64'(out_payload), 64'(ew_pay[wcnt]));
        if (out_a) wcnt++;
      end else if (started) begin
        chk("rr_bubble", 64'(out_v), 64'd1);
      end
      tick();
    end
    chk("rr_words_done", 64'(wcnt), 64'd8);
    chk("rr_grants", 64'(gcnt), 64'd6);

    // Reset in the middle of a two-word message
    do_reset();
    in_v = 4'b0010;
    #1;
    chk("mid_grant1", 64'(in_a), 64'(4'b0010));
    tick();
    in_v = 4'b0000;
    tick();
    chk_word("mid_w1", 7'd17, 20'h12345);
    #2;
    reset = 1'b0;
    in_v  = 4'hF;
    #1;
    chk("mid_async_v", 64'(out_v), 64'd0);
    chk("mid_async_in_a", 64'(in_a), 64'd0);
    tick();
    chk("mid_hold_v", 64'(out_v), 64'd0);
    chk("mid_hold_in_a", 64'(in_a), 64'd0);
    reset = 1'b1;
    in_v  = 4'b0011;
    #1;
    chk("mid_post_grant", 64'(in_a), 64'(4'b0001));
    tick();
    in_v = 4'b0000;
    chk_word("mid_post_w", 7'd14, 20'hABCDE);
    tick();

`ifdef PC_UPSTREAM_FRAMER_HB_EN
    // Basic heartbeat
    do_reset();
    time_elapsed = 48'h0000_0123_4567;
    hb_pulse = 1'b1;
    tick();
    hb_pulse = 1'b0;
    #1;
    chk("hb_in_a", 64'(in_a), 64'd0);
    tick();
    chk_word("hb_w0", 7'd24, 20'h34567);
    tick();
    chk_word("hb_w1", 7'd25, 20'h00012);
    tick();
    chk_word("hb_w2", 7'd26, 20'h00000);
    tick();
    chk("hb_end_v", 64'(out_v), 64'd0);
    chk("hb_no_overrun", 64'(hb_overrun), 64'd0);

    // Second pulse while the heartbeat waits behind a stalled message
    do_reset();
    in_v = 4'b0001;
    tick();
    in_v = 4'b0000;
    out_a = 1'b0;
    time_elapsed = 48'h1111_1111_1111;
    hb_pulse = 1'b1;
    tick();
    chk("ovr_first_pulse", 64'(hb_overrun), 64'd0);
    time_elapsed = 48'h0000_0ABC_DEF0;
    tick();
    hb_pulse = 1'b0;
    out_a = 1'b1;
    #1;
    chk("ovr_set", 64'(hb_overrun), 64'd1);
    tick();
    chk_word("ovr_w0", 7'd24, 20'hCDEF0);
    tick();
    chk_word("ovr_w1", 7'd25, 20'h00ABC);
    tick();
    chk_word("ovr_w2", 7'd26, 20'h00000);
    chk("ovr_sticky", 64'(hb_overrun), 64'd1);
    tick();

    // Pulse in the heartbeat's own grant cycle queues a new heartbeat
    do_reset();
    time_elapsed = 48'h0000_0000_0005;
    hb_pulse = 1'b1;
    tick();
    time_elapsed = 48'h0000_0000_0777;
    tick();
    hb_pulse = 1'b0;
    chk_word("gc_a0", 7'd24, 20'h00005);
    chk("gc_no_overrun", 64'(hb_overrun), 64'd0);
    tick();
    tick();
    chk_word("gc_a2", 7'd26, 20'h00000);
    tick();
    chk_word("gc_b0", 7'd24, 20'h00777);
    chk("gc_no_overrun2", 64'(hb_overrun), 64'd0);
    tick();
    tick();
    tick();
`else
    // Heartbeat disabled: pulses produce nothing
    do_reset();
    time_elapsed = 48'h0000_0123_4567;
    for (int c = 0; c < 6; c++) begin
      hb_pulse = (c % 2 == 0);
      tick();
      chk($sformatf("nohb_v%0d", c), 64'(out_v), 64'd0);
      chk($sformatf("nohb_ovr%0d", c), 64'(hb_overrun), 64'd0);
    end
    hb_pulse = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
